// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the result broadcast bus between the ALU and LSB.
// Two private FIFOs, round-robin pop, registered {rob_idx, val} output.
module cdb_arbiter #(
  parameter int ROB_IDX_BITS   = 4,
  parameter int DATA_BITS      = 32,
  parameter int FIFO_DEPTH_LOG = 2
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    roll_back,
  input  logic                    alu_in_en,
  input  logic [ROB_IDX_BITS-1:0] alu_rob_idx,
  input  logic [DATA_BITS-1:0]    alu_val,
  output logic                    alu_full,
  input  logic                    lsb_in_en,
  input  logic [ROB_IDX_BITS-1:0] lsb_rob_idx,
  input  logic [DATA_BITS-1:0]    lsb_val,
  output logic                    lsb_full,
  output logic                    cdb_en,
  output logic [ROB_IDX_BITS-1:0] cdb_rob_idx,
  output logic [DATA_BITS-1:0]    cdb_val
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int AW    = FIFO_DEPTH_LOG;
  localparam int CW    = FIFO_DEPTH_LOG + 1;
  localparam int EW    = ROB_IDX_BITS + DATA_BITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_LSB = 1'b1;

  logic [EW-1:0] mem_q [2][DEPTH];
  logic [AW-1:0] head_q [2];
  logic [AW-1:0] head_d [2];
  logic [AW-1:0] tail_q [2];
  logic [AW-1:0] tail_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [EW-1:0] din    [2];
  logic          last_q, last_d;
  logic          cdb_en_q, cdb_en_d;
  logic [EW-1:0] cdb_q, cdb_d;
  logic [1:0]    in_en, ne, full, push, gnt;
  logic          go;

  assign in_en  = {lsb_in_en, alu_in_en};
  assign din[0] = {alu_rob_idx, alu_val};
  assign din[1] = {lsb_rob_idx, lsb_val};
  assign go     = rdy_in && !roll_back;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ne[s]   = cnt_q[s] != '0;
      full[s] = cnt_q[s] == FULL_CNT;
      push[s] = go && in_en[s] && !full[s];
    end
    gnt = 2'b00;
    if (go) begin
      unique case (1'b1)
        ne[0] && (!ne[1] || last_q == LAST_LSB): gnt = 2'b01;
        ne[1] && (!ne[0] || last_q == LAST_ALU): gnt = 2'b10;
        default:                                 gnt = 2'b00;
      endcase
    end
    for (int s = 0; s < 2; s++) begin
      head_d[s] = head_q[s] + AW'(gnt[s]);
      tail_d[s] = tail_q[s] + AW'(push[s]);
      cnt_d[s]  = cnt_q[s] + CW'(push[s]) - CW'(gnt[s]);
    end
    last_d   = last_q;
    cdb_en_d = cdb_en_q;
    cdb_d    = cdb_q;
    if (rdy_in) begin
      if (roll_back) begin
        for (int s = 0; s < 2; s++) begin
          head_d[s] = '0;
          tail_d[s] = '0;
          cnt_d[s]  = '0;
        end
        last_d   = LAST_LSB;
        cdb_en_d = 1'b0;
      end else begin
        cdb_en_d = |gnt;
        if (gnt[0]) begin
          cdb_d  = mem_q[0][head_q[0]];
          last_d = LAST_ALU;
        end
        if (gnt[1]) begin
          cdb_d  = mem_q[1][head_q[1]];
          last_d = LAST_LSB;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][tail_q[s]] <= din[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_q   <= LAST_LSB;
      cdb_en_q <= 1'b0;
      cdb_q    <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= head_d[s];
        tail_q[s] <= tail_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      last_q   <= last_d;
      cdb_en_q <= cdb_en_d;
      cdb_q    <= cdb_d;
    end
  end

  assign alu_full                 = full[0];
  assign lsb_full                 = full[1];
  assign cdb_en                   = cdb_en_q;
  assign {cdb_rob_idx, cdb_val}   = cdb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors for the CDB arbiter.
// Scoreboard queues track per-source order in the saturation run.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst_in, rdy_in, roll_back;
  logic        alu_in_en, lsb_in_en;
  logic [3:0]  alu_rob_idx, lsb_rob_idx;
  logic [31:0] alu_val, lsb_val;
  logic        alu_full, lsb_full, cdb_en;
  logic [3:0]  cdb_rob_idx;
  logic [31:0] cdb_val;

  int checks = 0;
  int errors = 0;

  cdb_arbiter dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .alu_in_en(alu_in_en), .alu_rob_idx(alu_rob_idx), .alu_val(alu_val),
    .alu_full(alu_full),
    .lsb_in_en(lsb_in_en), .lsb_rob_idx(lsb_rob_idx), .lsb_val(lsb_val),
    .lsb_full(lsb_full),
    .cdb_en(cdb_en), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_in && rdy_in && !roll_back) begin
      if (alu_in_en && alu_full) $error("push while alu_full");
      if (lsb_in_en && lsb_full) $error("push while lsb_full");
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_in_en = 0; lsb_in_en = 0;
  endtask

  task automatic push_alu(input logic [3:0] i, input logic [31:0] v);
    alu_in_en = 1; alu_rob_idx = i; alu_val = v;
  endtask

  task automatic push_lsb(input logic [3:0] i, input logic [31:0] v);
    lsb_in_en = 1; lsb_rob_idx = i; lsb_val = v;
  endtask

  task automatic do_reset();
    rst_in = 1; rdy_in = 1; roll_back = 0; idle();
    tick(); tick();
    rst_in = 0;
  endtask

  task automatic chk_bc(input string tag, input logic [3:0] i,
                        input logic [31:0] v);
    chk({tag, ".en"}, cdb_en, 1);
    chk({tag, ".idx"}, cdb_rob_idx, i);
    chk({tag, ".val"}, cdb_val, v);
  endtask

  logic [35:0] qa[$];
  logic [35:0] ql[$];
  logic [35:0] e;
  int acnt, lcnt, nbc;
  bit  exp_alu, saw_af, saw_lf, is_alu;

  initial begin
    alu_rob_idx = 0; alu_val = 0; lsb_rob_idx = 0; lsb_val = 0;
    do_reset();
    chk("rst.en", cdb_en, 0);
    chk("rst.idx", cdb_rob_idx, 0);
    chk("rst.val", cdb_val, 0);
    chk("rst.afull", alu_full, 0);
    chk("rst.lfull", lsb_full, 0);

    // single ALU entry, one cycle latency, single pulse
    push_alu(3, 32'h11); tick(); idle();
    chk("t1.nobypass", cdb_en, 0);
    tick(); chk_bc("t1.bc", 3, 32'h11);
    tick(); chk("t1.pulse", cdb_en, 0);

    // simultaneous push: ALU first after reset
    do_reset();
    push_alu(1, 32'hA); push_lsb(2, 32'hB); tick(); idle();
    tick(); chk_bc("t2.alu", 1, 32'hA);
    tick(); chk_bc("t2.lsb", 2, 32'hB);
    tick(); chk("t2.idle", cdb_en, 0);

    // saturation: both push whenever not full
    do_reset();
    acnt = 0; lcnt = 0; exp_alu = 1; saw_af = 0; saw_lf = 0;
    for (int k = 0; k < 40; k++) begin
      chk("t3.afull", alu_full, acnt == 4);
      chk("t3.lfull", lsb_full, lcnt == 4);
      if (alu_full) saw_af = 1;
      if (lsb_full) saw_lf = 1;
      idle();
      if (!alu_full) begin
        push_alu(4'(k), 32'h100 + k);
        qa.push_back({4'(k), 32'h100 + k}); acnt++;
      end
      if (!lsb_full) begin
        push_lsb(4'(k + 7), 32'h200 + k);
        ql.push_back({4'(k + 7), 32'h200 + k}); lcnt++;
      end
      tick();
      if (k > 0) chk("t3.busy", cdb_en, 1);
      if (cdb_en) begin
        is_alu = cdb_val[11:8] == 4'h1;
        chk("t3.alt", is_alu, exp_alu);
        exp_alu = !exp_alu;
        if (is_alu && qa.size() > 0) begin
          e = qa.pop_front(); acnt--;
        end else if (!is_alu && ql.size() > 0) begin
          e = ql.pop_front(); lcnt--;
        end else e = '1;
        chk("t3.data", {cdb_rob_idx, cdb_val}, e);
      end
    end
    chk("t3.saw_afull", saw_af, 1);
    chk("t3.saw_lfull", saw_lf, 1);
    idle();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cdb_en) begin
        is_alu = cdb_val[11:8] == 4'h1;
        if (is_alu && qa.size() > 0) e = qa.pop_front();
        else if (!is_alu && ql.size() > 0) e = ql.pop_front();
        else e = '1;
        chk("t3.drain", {cdb_rob_idx, cdb_val}, e);
      end
    end
    chk("t3.empty", qa.size() + ql.size(), 0);
    chk("t3.idle", cdb_en, 0);

    // roll_back with 3 ALU and 2 LSB pending
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle();
      push_alu(4'(k), 32'h300 + k);
      if (k < 4) push_lsb(4'(k + 8), 32'h400 + k);
      tick();
    end
    chk_bc("t4.prebc", 9, 32'h401);
    chk("t4.afull_pre", alu_full, 0);
    idle(); push_alu(15, 32'h3FF); roll_back = 1;
    tick(); roll_back = 0; idle();
    chk("t4.en", cdb_en, 0);
    chk("t4.afull", alu_full, 0);
    chk("t4.lfull", lsb_full, 0);
    nbc = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cdb_en) nbc++;
    end
    chk("t4.flushed", nbc, 0);
    push_alu(6, 32'h66); push_lsb(7, 32'h77); tick(); idle();
    tick(); chk_bc("t4.rr", 6, 32'h66);
    tick(); chk_bc("t4.rr2", 7, 32'h77);

    // rdy_in low freezes an active broadcast and a pending entry
    do_reset();
    push_alu(4, 32'h44); tick();
    push_alu(5, 32'h55); tick(); idle();
    chk_bc("t5.first", 4, 32'h44);
    rdy_in = 0;
    push_lsb(1, 32'hDEAD);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bc("t5.frozen", 4, 32'h44);
    end
    idle(); rdy_in = 1;
    tick(); chk_bc("t5.resume", 5, 32'h55);
    tick(); chk("t5.idle", cdb_en, 0);

    // 10 back-to-back ALU pushes across pointer wrap
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      idle();
      if (i < 10) push_alu(4'(i), 32'h600 + i);
      tick();
      if (i > 0) chk_bc("t6.bc", 4'(i - 1), 32'h600 + i - 1);
    end
    idle();
    tick(); chk("t6.idle", cdb_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
